// File: rtl/spi_txn_sched_pkg.sv
// spi_txn_sched_pkg: shared types, widths and helpers for the spi transaction scheduler
package spi_txn_sched_pkg;
    localparam int ADDR_W = 3;
    localparam int MEM_DEPTH_DEF = 5;
    localparam int XFER_CYCLES_DEF = 21;
    localparam int GAP_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2,
        REJ  = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int depth);
        return int'(a) < depth;
    endfunction
endpackage

// File: rtl/spi_txn_sched_if.sv
// spi_txn_sched_if: requester handshake plus the control bundle driven into the spi pair
interface spi_txn_sched_if
    import spi_txn_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_rw;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [ADDR_W*NREQ-1:0] req_saddr;
    logic [ADDR_W*NREQ-1:0] req_raddr;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic [NREQ-1:0] err;
    logic ss;
    logic rw;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] saddr;
    logic [ADDR_W-1:0] raddr;
    logic busy;

    modport master (
        output req, req_rw, req_addr, req_saddr, req_raddr,
        input  gnt, done, err, ss, rw, addr, saddr, raddr, busy
    );

    modport slave (
        input  req, req_rw, req_addr, req_saddr, req_raddr,
        output gnt, done, err, ss, rw, addr, saddr, raddr, busy
    );
endinterface

// File: rtl/spi_txn_sched_rr_arbiter.sv
// spi_txn_sched_rr_arbiter: combinational round-robin pick, first set bit at or above ptr
module spi_txn_sched_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);
    logic [IW-1:0] k;

    // Scan from farthest to nearest so the closest hit to ptr is the one that sticks.
    always_comb begin
        gnt = '0;
        idx = '0;
        valid = 1'b0;
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NREQ);
            if (req[k]) begin
                idx = k;
                valid = 1'b1;
            end
        end
        if (valid) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/spi_txn_sched.sv
// spi_txn_sched: round-robin owner of one spi master/slave pair; runs one full
// exchange window per grant, then a guard gap, then pulses done to the requester.
module spi_txn_sched
    import spi_txn_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int XFER_CYCLES = XFER_CYCLES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input logic sclk,
    input logic rst,
    spi_txn_sched_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(max_int(XFER_CYCLES, GAP_CYCLES) + 1);

    state_t state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] g;
    logic [IW-1:0] g_next;
    logic [IW-1:0] pick_idx;
    logic [NREQ-1:0] pick;
    logic pick_valid;
    logic [CW-1:0] cnt;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] ra;
    logic bad;

    // A requester is ignored while its own done is showing, so holding req
    // through done never looks like a fresh request.
    spi_txn_sched_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (bus.req & ~bus.done),
        .ptr   (ptr),
        .gnt   (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign a = bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign sa = bus.req_saddr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign ra = bus.req_raddr[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign bad = !(addr_ok(a, MEM_DEPTH) && addr_ok(sa, MEM_DEPTH) && addr_ok(ra, MEM_DEPTH));
    assign g_next = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            g <= '0;
            cnt <= '0;
            bus.ss <= 1'b1;
            bus.rw <= 1'b0;
            bus.addr <= '0;
            bus.saddr <= '0;
            bus.raddr <= '0;
            bus.gnt <= '0;
            bus.done <= '0;
            bus.err <= '0;
            bus.busy <= 1'b0;
        end else begin
            bus.done <= '0;
            bus.err <= '0;
            if (|bus.done) bus.gnt <= '0;
            case (state)
                IDLE: if (pick_valid) begin
                    bus.gnt <= pick;
                    g <= pick_idx;
                    bus.rw <= bus.req_rw[pick_idx];
                    bus.addr <= a;
                    bus.saddr <= sa;
                    bus.raddr <= ra;
                    bus.busy <= 1'b1;
                    if (bad) begin
                        state <= REJ;
                    end else begin
                        state <= XFER;
                        bus.ss <= 1'b0;
                        cnt <= CW'(XFER_CYCLES - 1);
                    end
                end
                XFER: if (cnt == '0) begin
                    state <= GAP;
                    bus.ss <= 1'b1;
                    cnt <= CW'(GAP_CYCLES - 1);
                    if (GAP_CYCLES == 1) begin
                        bus.done[g] <= 1'b1;
                        ptr <= g_next;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                // done is launched one edge early so it is visible on the last gap cycle.
                GAP: if (cnt == '0) begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bus.done[g] <= 1'b1;
                        ptr <= g_next;
                    end
                end
                REJ: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done[g] <= 1'b1;
                    bus.err[g] <= 1'b1;
                    ptr <= g_next;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_sched.sv
// tb_spi_txn_sched: directed plus randomized checks of spi_txn_sched against a
// transaction-level round-robin model.
module tb_spi_txn_sched;
    localparam int N = 4;
    localparam int DEPTH = 5;
    localparam int XC = 21;

    logic sclk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int ptr_m = 0;
    logic frw [N];
    logic [2:0] fa [N];
    logic [2:0] fs [N];
    logic [2:0] fr [N];

    spi_txn_sched_if #(.NREQ(N)) bus ();

    spi_txn_sched #(.NREQ(N)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_m(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_fields(input int i, input logic w, input logic [2:0] a, input logic [2:0] s, input logic [2:0] r);
        frw[i] = w;
        fa[i] = a;
        fs[i] = s;
        fr[i] = r;
        bus.req_rw[i] = w;
        bus.req_addr[3*i +: 3] = a;
        bus.req_saddr[3*i +: 3] = s;
        bus.req_raddr[3*i +: 3] = r;
    endtask

    // One transaction from the model's point of view: who wins, whether it is
    // rejected, how long ss stays low and where done/err land.
    task automatic do_txn(input bit drop, input int drop_mid, output int gc);
        int eg;
        int n;
        int lows;
        bit bad_m;
        eg = pick_m(bus.req, ptr_m);
        if (eg < 0) eg = 0;
        bad_m = (fa[eg] >= DEPTH) || (fs[eg] >= DEPTH) || (fr[eg] >= DEPTH);
        @(negedge sclk);
        check("done_single_pulse", bus.done, 0);
        n = 1;
        while (bus.gnt == '0 && n < 40) begin
            @(negedge sclk);
            n++;
        end
        gc = cyc;
        check("grant_seen", (bus.gnt != '0), 1);
        check("gnt_onehot", bus.gnt, 32'(1) << eg);
        check("busy_on", bus.busy, 1);
        check("rw_latched", bus.rw, frw[eg]);
        check("addrs_latched", {bus.addr, bus.saddr, bus.raddr}, {fa[eg], fs[eg], fr[eg]});
        if (!bad_m) begin
            check("ss_fall", bus.ss, 0);
            lows = 1;
            n = 0;
            while (n < 40) begin
                @(negedge sclk);
                n++;
                if (lows == drop_mid) bus.req[eg] = 1'b0;
                if (bus.ss !== 1'b0) break;
                lows++;
            end
            check("ss_low_cycles", lows, XC);
            check("done_not_early", bus.done, 0);
            @(negedge sclk);
            check("done_xfer", bus.done, 32'(1) << eg);
            check("err_xfer", bus.err, 0);
            check("ss_gap", bus.ss, 1);
            check("gnt_through_done", bus.gnt, 32'(1) << eg);
        end else begin
            check("ss_rej_grant", bus.ss, 1);
            @(negedge sclk);
            check("done_rej", bus.done, 32'(1) << eg);
            check("err_rej", bus.err, 32'(1) << eg);
            check("ss_rej", bus.ss, 1);
            check("busy_rej_idle", bus.busy, 0);
        end
        if (drop) bus.req[eg] = 1'b0;
        ptr_m = (eg + 1) % N;
    endtask

    initial begin
        int g0;
        int g1;
        int rc;
        int n;
        logic [N-1:0] m;
        logic saw;
        bus.req = '0;
        bus.req_rw = '0;
        bus.req_addr = '0;
        bus.req_saddr = '0;
        bus.req_raddr = '0;
        for (int i = 0; i < N; i++) set_fields(i, 1'b0, 3'd0, 3'd0, 3'd0);
        repeat (3) @(negedge sclk);
        check("rst_ss", bus.ss, 1);
        check("rst_gnt", bus.gnt, 0);
        check("rst_done_err", {bus.done, bus.err}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ctrl", {bus.rw, bus.addr, bus.saddr, bus.raddr}, 0);
        rst = 1'b0;

        // All four held: strict rotation, 24-cycle spacing between grants.
        for (int i = 0; i < N; i++)
            set_fields(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)));
        bus.req = '1;
        do_txn(0, -1, g0);
        for (int t = 1; t < 6; t++) begin
            check("rr_order", ptr_m, t % N);
            do_txn(0, -1, g1);
            check("rr_spacing", g1 - g0, XC + 3);
            g0 = g1;
        end
        bus.req = '0;
        repeat (3) @(negedge sclk);

        // Single request, fixed fields, exact latency.
        set_fields(0, 1'b1, 3'd2, 3'd1, 3'd3);
        bus.req = 4'b0001;
        rc = cyc;
        do_txn(1, -1, g0);
        check("single_latency", g0 - rc, 1);
        repeat (3) @(negedge sclk);

        // Back-to-back on one requester.
        bus.req = 4'b0001;
        do_txn(0, -1, g0);
        do_txn(1, -1, g1);
        check("b2b_spacing", g1 - g0, XC + 3);
        repeat (3) @(negedge sclk);

        // Bad address on requester 1 while requester 2 waits.
        set_fields(1, 1'b0, 3'd5, 3'd0, 3'd0);
        set_fields(2, 1'b1, 3'd4, 3'd4, 3'd0);
        ptr_m = pick_m(4'b0010, ptr_m) >= 0 ? ptr_m : ptr_m;
        bus.req = 4'b0010;
        rc = cyc;
        do_txn(1, -1, g0);
        check("rej_latency", g0 - rc, 1);
        bus.req[2] = 1'b1;
        do_txn(1, 10, g1);
        check("after_rej_spacing", g1 - g0, 2);
        repeat (3) @(negedge sclk);

        // Requester 2 drops req mid-transfer; ends with pointer at 3.
        bus.req = 4'b0100;
        do_txn(1, 10, g0);
        repeat (3) @(negedge sclk);

        // Reset in the middle of requester 3's transfer.
        set_fields(3, 1'b0, 3'd1, 3'd2, 3'd3);
        set_fields(1, 1'b1, 3'd0, 3'd4, 3'd2);
        bus.req = 4'b1000;
        n = 0;
        do begin @(negedge sclk); n++; end while (bus.gnt == '0 && n < 10);
        check("pre_rst_gnt", bus.gnt, 4'b1000);
        repeat (9) @(negedge sclk);
        check("pre_rst_ss", bus.ss, 0);
        rst = 1'b1;
        bus.req = '0;
        @(negedge sclk);
        rst = 1'b0;
        check("mid_rst_ss", bus.ss, 1);
        check("mid_rst_gnt", bus.gnt, 0);
        check("mid_rst_busy", bus.busy, 0);
        saw = 1'b0;
        repeat (30) begin
            @(negedge sclk);
            saw = saw | (|bus.done);
        end
        check("mid_rst_no_done", saw, 0);
        ptr_m = 0;
        bus.req = 4'b1010;
        do_txn(1, -1, g0);
        do_txn(1, -1, g1);
        repeat (3) @(negedge sclk);

        // Randomized batches of simultaneous requests.
        for (int r = 0; r < 6; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++)
                set_fields(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)));
            bus.req = m;
            for (int k = 0; k < N && bus.req != '0; k++) do_txn(1, -1, g0);
            check("batch_drained", bus.req, 0);
            repeat (3) @(negedge sclk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
